conv3x3_filter: RTL and testbench

CONV3X3_FILTER -- requirements
Module: conv3x3_filter

---
 rtl/conv3x3_filter.sv | 207 ++++++++++++++++++++
 tb/tb_conv3x3_filter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: streaming 3x3 filter (bypass / gaussian / sharpen) over two line buffers, 3-clk latency.
// Define CONV3X3_FILTER_FRAME_CHK_EN to add the frame_err output that flags malformed sop/eop framing.
module conv3x3_filter #(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic          din_sop,
  input  logic          din_eop,
  input  logic          din_vld,
  input  logic [DW-1:0] din,
`ifdef CONV3X3_FILTER_FRAME_CHK_EN
  output logic          frame_err,
`endif
  output logic          dout_sop,
  output logic          dout_eop,
  output logic          dout_vld,
  output logic [DW-1:0] dout
);
  localparam int SW = DW + 4;
  localparam logic [1:0]    MODE_GAUSS = 2'd1;
  localparam logic [1:0]    MODE_SHARP = 2'd2;
  localparam logic [1:0]    ROW_SAT    = 2'd2;
  localparam logic [AW-1:0] COL_LAST   = AW'(IMG_W - 1);

  // Two's-complement SW-bit value clamped to the unsigned pixel range.
  function automatic logic [DW-1:0] clamp_px(input logic [SW-1:0] v);
    logic [DW-1:0] r;
    if (v[SW-1]) begin
      r = '0;
    end else if (v[SW-2:DW] != '0) begin
      r = '1;
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

  logic [DW-1:0] lb_a [0:IMG_W-1];
  logic [DW-1:0] lb_b [0:IMG_W-1];

  logic [AW-1:0]         col_q, col_d, cur_col;
  logic [1:0]            row_q, row_d, cur_row;
  logic [1:0]            mode_q, mode_d;
  logic [2:0][DW-1:0]    top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic [1:0]            s1_mode_q, s1_mode_d;
  logic                  s1_border_q, s1_border_d;
  logic                  v1_q, v1_d, v2_q, v2_d, vld_q, vld_d;
  logic                  sop1_q, sop1_d, sop2_q, sop2_d, sop_q, sop_d;
  logic                  eop1_q, eop1_d, eop2_q, eop2_d, eop_q, eop_d;
  logic [DW-1:0]         res2_q, res2_d, dout_q, dout_d;
  logic [DW-1:0]         rd_a, rd_b;
  logic [SW-1:0]         gsum, ssum;

  // Position tracking, window shifting and the three data/flag pipeline stages.
  always_comb begin
    cur_col = din_sop ? '0 : col_q;
    cur_row = din_sop ? 2'd0 : row_q;
    rd_a    = lb_a[cur_col];
    rd_b    = lb_b[cur_col];

    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    s1_mode_d   = s1_mode_q;
    s1_border_d = s1_border_q;
    if (din_vld) begin
      // row only needs to distinguish 0, 1 and "2 or more", so it saturates.
      if (din_eop) begin
        col_d = '0;
        row_d = 2'd0;
      end else if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_SAT) ? ROW_SAT : cur_row + 2'd1;
      end else begin
        col_d = cur_col + AW'(1);
        row_d = cur_row;
      end
      mode_d      = din_sop ? mode : mode_q;
      s1_mode_d   = din_sop ? mode : mode_q;
      s1_border_d = (cur_row < ROW_SAT) || (cur_col < AW'(2));
      top_d       = {rd_b, top_q[2:1]};
      mid_d       = {rd_a, mid_q[2:1]};
      bot_d       = {din,  bot_q[2:1]};
    end else begin
      col_d = col_q;
    end

    gsum = SW'(top_q[0]) + SW'(top_q[2]) + SW'(bot_q[0]) + SW'(bot_q[2])
         + (SW'(top_q[1]) << 1) + (SW'(mid_q[0]) << 1)
         + (SW'(mid_q[2]) << 1) + (SW'(bot_q[1]) << 1)
         + (SW'(mid_q[1]) << 2);
    ssum = (SW'(mid_q[1]) << 2) + SW'(mid_q[1])
         - SW'(top_q[1]) - SW'(bot_q[1]) - SW'(mid_q[0]) - SW'(mid_q[2]);

    res2_d = res2_q;
    if (v1_q) begin
      if (s1_border_q) begin
        res2_d = bot_q[2];
      end else begin
        case (s1_mode_q)
          MODE_GAUSS: res2_d = gsum[SW-1:4];
          MODE_SHARP: res2_d = clamp_px(ssum);
          default:    res2_d = bot_q[2];
        endcase
      end
    end else begin
      res2_d = res2_q;
    end

    dout_d = v2_q ? res2_q : dout_q;
    v1_d   = din_vld;
    v2_d   = v1_q;
    vld_d  = v2_q;
    sop1_d = din_vld & din_sop;
    sop2_d = sop1_q;
    sop_d  = sop2_q;
    eop1_d = din_vld & din_eop;
    eop2_d = eop1_q;
    eop_d  = eop2_q;
  end

  // Line-buffer storage: the new pixel enters row r-1 while the old r-1 pixel moves to r-2.
  always_ff @(posedge clk) begin
    if (din_vld) begin
      lb_a[cur_col] <= din;
      lb_b[cur_col] <= rd_a;
    end
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= 2'd0;
      mode_q      <= 2'd0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
      s1_mode_q   <= 2'd0;
      s1_border_q <= 1'b0;
      res2_q      <= '0;
      dout_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      vld_q       <= 1'b0;
      sop1_q      <= 1'b0;
      sop2_q      <= 1'b0;
      sop_q       <= 1'b0;
      eop1_q      <= 1'b0;
      eop2_q      <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
      s1_mode_q   <= s1_mode_d;
      s1_border_q <= s1_border_d;
      res2_q      <= res2_d;
      dout_q      <= dout_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      vld_q       <= vld_d;
      sop1_q      <= sop1_d;
      sop2_q      <= sop2_d;
      sop_q       <= sop_d;
      eop1_q      <= eop1_d;
      eop2_q      <= eop2_d;
      eop_q       <= eop_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign dout_sop = sop_q;
  assign dout_eop = eop_q;

`ifdef CONV3X3_FILTER_FRAME_CHK_EN
  logic frame_err_q, frame_err_d;

  // Flag an eop short of the line end, or a sop arriving while a frame is still open.
  always_comb begin
    frame_err_d = din_vld && ((din_eop && (cur_col != COL_LAST)) ||
                              (din_sop && ((row_q != 2'd0) || (col_q != '0))));
  end

  // One-cycle registered error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif
endmodule

// File: tb/tb_conv3x3_filter.sv
// Bench for conv3x3_filter (IMG_W=8, DW=8): directed frames with random pixels/gaps vs. a frame-level model.
module tb_conv3x3_filter;
  localparam int W  = 8;
  localparam int NR = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       din_sop = 1'b0, din_eop = 1'b0, din_vld = 1'b0;
  logic [7:0] din = 8'd0;
  logic       dout_sop, dout_eop, dout_vld;
  logic [7:0] dout;
`ifdef CONV3X3_FILTER_FRAME_CHK_EN
  logic       frame_err;
`endif

  conv3x3_filter #(.DW(8), .IMG_W(W), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .din_sop(din_sop), .din_eop(din_eop), .din_vld(din_vld), .din(din),
`ifdef CONV3X3_FILTER_FRAME_CHK_EN
    .frame_err(frame_err),
`endif
    .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_vld(dout_vld), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         img [0:NR-1][0:W-1];
  int         gk  [0:2][0:2] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         gap_pct = 0;
  int         err_cyc = -1;
  logic [1:0] mode_in = 2'd0;
  logic [1:0] frame_mode = 2'd0;
  logic [7:0] last_dout = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected output for input pixel (r,c) of the current frame, straight from the filter definition.
  function automatic int exp_px(input int r, input int c);
    int s;
    if (r < 2 || c < 2 || !(frame_mode == 2'd1 || frame_mode == 2'd2)) return img[r][c];
    if (frame_mode == 2'd1) begin
      s = 0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          s += gk[dr][dc] * img[r-2+dr][c-2+dc];
      return s / 16;
    end
    s = 5 * img[r-1][c-1] - img[r-2][c-1] - img[r][c-1] - img[r-1][c-2] - img[r-1][c];
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    exp_q.delete();
    err_cyc = -1;
    @(negedge clk);
    n_tests++;
    assert ({dout_vld, dout_sop, dout_eop, dout} === 11'd0)
      else begin n_fail++; $error("FAIL reset_outputs: got %h, expected 000", {dout_vld, dout_sop, dout_eop, dout}); end
    #1 rst_n = 1'b1;
  endtask

  task automatic drive_px(input int r, input int c, input logic sop, input logic eop);
    exp_t e;
    while ($urandom_range(0, 99) < gap_pct) idle(1);
    @(negedge clk);
    din = 8'(img[r][c]); din_sop = sop; din_eop = eop; din_vld = 1'b1; mode = mode_in;
    if (sop) frame_mode = mode_in;
    e.d   = 8'(exp_px(r, c));
    e.sop = sop;
    e.eop = eop;
    e.cyc = cyc + 3;
    exp_q.push_back(e);
    if (eop && c != W - 1) err_cyc = cyc + 1;
  endtask

  // pat: 0 flat 100, 1 single 255 at (3,3), 2 ramp col*16, else random.
  task automatic run_frame(input int nrows, input int pat, input logic [1:0] m0, input int sw_row,
                           input logic [1:0] m1, input int rst_r, input int rst_c, input int eop_c);
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0:       img[r][c] = 100;
          1:       img[r][c] = (r == 3 && c == 3) ? 255 : 0;
          2:       img[r][c] = c * 16;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
    mode_in = m0;
    for (int r = 0; r < nrows; r++)
      for (int c = 0; c < W; c++) begin
        if (r == sw_row && c == 0) mode_in = m1;
        if (r == rst_r && c == rst_c) begin
          do_reset();
          return;
        end
        drive_px(r, c, (r == 0 && c == 0), (r == nrows - 1 && c == eop_c));
        if (r == nrows - 1 && c == eop_c) return;
      end
  endtask

  // Output monitor: order, data, flags and exact latency of every dout_vld, plus hold when idle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_vld) begin
        n_tests++;
        assert (exp_q.size() > 0)
          else begin n_fail++; $error("FAIL stray_vld: got dout_vld=1 at cyc %0d, expected 0", cyc); end
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          n_tests++;
          assert (dout === mon_e.d)
            else begin n_fail++; $error("FAIL dout: got %0d, expected %0d (cyc %0d)", dout, mon_e.d, cyc); end
          n_tests++;
          assert ({dout_sop, dout_eop} === {mon_e.sop, mon_e.eop})
            else begin n_fail++; $error("FAIL sop_eop: got %b%b, expected %b%b", dout_sop, dout_eop, mon_e.sop, mon_e.eop); end
          n_tests++;
          assert (cyc === mon_e.cyc)
            else begin n_fail++; $error("FAIL latency: got output at cyc %0d, expected cyc %0d", cyc, mon_e.cyc); end
        end
      end else begin
        n_tests++;
        assert (dout === last_dout)
          else begin n_fail++; $error("FAIL dout_hold: got %0d, expected %0d", dout, last_dout); end
      end
`ifdef CONV3X3_FILTER_FRAME_CHK_EN
      n_tests++;
      assert (frame_err === (cyc == err_cyc))
        else begin n_fail++; $error("FAIL frame_err: got %b, expected %b (cyc %0d)", frame_err, (cyc == err_cyc), cyc); end
`endif
    end
    last_dout = dout;
  end

  initial begin
    do_reset();
    gap_pct = 0;
    run_frame(NR, 0, 2'd1, -1, 2'd1, -1, -1, W - 1);   // flat 100 gaussian
    idle(2);
    run_frame(NR, 1, 2'd2, -1, 2'd2, -1, -1, W - 1);   // sharpen impulse
    idle(2);
    run_frame(NR, 2, 2'd1, -1, 2'd1, -1, -1, W - 1);   // ramp, gap-free
    gap_pct = 50;
    run_frame(NR, 2, 2'd1, -1, 2'd1, -1, -1, W - 1);   // ramp with gaps
    gap_pct = 0;
    run_frame(NR, 3, 2'd1, 4, 2'd2, -1, -1, W - 1);    // mode change mid-frame
    gap_pct = 30;
    run_frame(NR, 3, 2'd2, -1, 2'd2, -1, -1, W - 1);   // new frame picks up sharpen
    run_frame(NR, 3, 2'd3, -1, 2'd3, -1, -1, W - 1);
    gap_pct = 0;
    run_frame(NR, 3, 2'd0, -1, 2'd0, -1, -1, W - 1);
    run_frame(1, 3, 2'd2, -1, 2'd2, -1, -1, 0);        // single-pixel frame
    idle(2);
    run_frame(NR, 3, 2'd1, -1, 2'd1, 5, 3, W - 1);     // reset mid-frame
    gap_pct = 20;
    run_frame(NR, 3, 2'd1, -1, 2'd1, -1, -1, W - 1);
    gap_pct = 0;
    idle(6);
    run_frame(3, 3, 2'd1, -1, 2'd1, -1, -1, 5);        // short last line
    idle(6);
    run_frame(3, 3, 2'd2, -1, 2'd2, -1, -1, W - 1);
    idle(8);
    n_tests++;
    assert (exp_q.size() == 0)
      else begin n_fail++; $error("FAIL drain: got %0d outputs missing, expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
